lmc_out_display: RTL and testbench



---
 rtl/lmc_disp_pkg.sv | 40 ++++
 rtl/lmc_out_display_bin2bcd.sv | 53 +++++
 rtl/lmc_out_display.sv | 154 +++++++++++++++
 tb/tb_lmc_out_display.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/lmc_disp_pkg.sv
// Shared types and constants for the LMC OUT-register display path:
// FSM state encoding, special segment patterns and the digit decoder.
package lmc_disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Active-low segments, bit0 = a .. bit6 = g.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Digit patterns, entry 9 first so that SEG_TABLE[d] selects digit d.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    // Non-decimal nibbles never occur after a valid conversion; they blank.
    function automatic logic [6:0] seg7(input logic [3:0] digit);
        logic [6:0] seg;
        if (digit <= 4'd9) begin
            seg = SEG_TABLE[digit];
        end else begin
            seg = SEG_BLANK;
        end
        return seg;
    endfunction

endpackage

// File: rtl/lmc_out_display_bin2bcd.sv
// Iterative double-dabble core. A start pulse loads the magnitude and
// clears the BCD accumulator; the following VAL_W cycles each perform one
// add-3 / shift step. done is high during the final step, so the BCD result
// is valid from the cycle after done and holds until the next start.
module bin2bcd_seq #(
    parameter int VAL_W = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [VAL_W-1:0] mag_in,
    output logic             done,
    output logic [15:0]      bcd
);

    localparam int CNT_W = $clog2(VAL_W + 1);

    logic [CNT_W-1:0] step_cnt;
    logic [VAL_W-1:0] mag;
    logic [15:0]      bcd_r;
    logic [15:0]      bcd_adj;

    // Add 3 to every nibble that is 5 or more before the next shift.
    always_comb begin
        bcd_adj = bcd_r;
        for (int n = 0; n < 4; n++) begin
            if (bcd_r[n*4 +: 4] >= 4'd5) begin
                bcd_adj[n*4 +: 4] = bcd_r[n*4 +: 4] + 4'd3;
            end
        end
    end

    // Load on start, otherwise shift {bcd, mag} left while steps remain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_cnt <= '0;
            mag      <= '0;
            bcd_r    <= '0;
        end else if (start) begin
            step_cnt <= CNT_W'(VAL_W);
            mag      <= mag_in;
            bcd_r    <= '0;
        end else if (step_cnt != '0) begin
            step_cnt <= step_cnt - CNT_W'(1);
            bcd_r    <= {bcd_adj[14:0], mag[VAL_W-1]};
            mag      <= {mag[VAL_W-2:0], 1'b0};
        end
    end

    assign done = (step_cnt == CNT_W'(1));
    assign bcd  = bcd_r;

endmodule

// File: rtl/lmc_out_display.sv
// Displays the LMC CPU OUT register as signed decimal on HEX3..HEX0.
// value_in is synchronised into clk, filtered until it has held still,
// then converted by bin2bcd_seq and latched into the segment outputs.
// Optional build macro LMC_DISP_LZB_EN: blank leading zero digits.
module lmc_out_display
    import lmc_disp_pkg::*;
#(
    parameter int VAL_W         = 11,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [VAL_W-1:0] value_in,
    output logic [6:0]       hex0,
    output logic [6:0]       hex1,
    output logic [6:0]       hex2,
    output logic [6:0]       hex3,
    output logic             busy,
    output logic             overflow,
    output logic             update_pulse
);

    localparam int STB_W = $clog2(STABLE_CYCLES) + 1;
    localparam logic [STB_W-1:0] STB_MAX = STB_W'(STABLE_CYCLES - 1);

    logic [VAL_W-1:0] sync1, sync2, samp, last_val;
    logic [STB_W-1:0] stb_cnt;
    logic             force_conv;
    logic             neg_r;
    logic             same, stable, start;
    logic [VAL_W-1:0] mag_in;
    logic             core_done;
    logic [15:0]      bcd;
    state_t           state, state_nxt;
    logic [6:0]       hex0_nxt, hex1_nxt, hex2_nxt, hex3_nxt;
    logic             ovf_nxt;

    // Two-flop synchroniser, previous-sample register and stability counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= '0;
            sync2   <= '0;
            samp    <= '0;
            stb_cnt <= '0;
        end else begin
            sync1 <= value_in;
            sync2 <= sync1;
            samp  <= sync2;
            if (sync2 != samp) begin
                stb_cnt <= '0;
            end else if (stb_cnt != STB_MAX) begin
                stb_cnt <= stb_cnt + STB_W'(1);
            end
        end
    end

    // Stable only while the current sample still matches the counted history,
    // so the first cycle of a new value cannot ride on an old saturated count.
    assign same   = (sync2 == samp);
    assign stable = same && (stb_cnt == STB_MAX);
    assign start  = (state == IDLE) && stable && ((sync2 != last_val) || force_conv);
    assign mag_in = sync2[VAL_W-1] ? (VAL_W'(0) - sync2) : sync2;

    // Remember what was handed to the converter and its sign.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_val   <= '0;
            force_conv <= 1'b1;
            neg_r      <= 1'b0;
        end else if (start) begin
            last_val   <= sync2;
            force_conv <= 1'b0;
            neg_r      <= sync2[VAL_W-1];
        end
    end

    bin2bcd_seq #(
        .VAL_W (VAL_W)
    ) u_bin2bcd (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mag_in (mag_in),
        .done   (core_done),
        .bcd    (bcd)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (core_done) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM output logic: display values to latch when leaving DONE.
    always_comb begin
        ovf_nxt  = (bcd[15:12] != 4'd0);
        hex0_nxt = seg7(bcd[3:0]);
        hex1_nxt = seg7(bcd[7:4]);
        hex2_nxt = seg7(bcd[11:8]);
        hex3_nxt = neg_r ? SEG_DASH : SEG_BLANK;
`ifdef LMC_DISP_LZB_EN
        if (bcd[11:8] == 4'd0) begin
            hex2_nxt = SEG_BLANK;
            if (bcd[7:4] == 4'd0) begin
                hex1_nxt = SEG_BLANK;
            end
        end
`endif
        if (ovf_nxt) begin
            hex0_nxt = SEG_DASH;
            hex1_nxt = SEG_DASH;
            hex2_nxt = SEG_DASH;
            hex3_nxt = SEG_DASH;
        end
    end

    // Output registers, loaded once per conversion in DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hex0         <= SEG_BLANK;
            hex1         <= SEG_BLANK;
            hex2         <= SEG_BLANK;
            hex3         <= SEG_BLANK;
            overflow     <= 1'b0;
            update_pulse <= 1'b0;
        end else begin
            update_pulse <= (state == DONE);
            if (state == DONE) begin
                hex0     <= hex0_nxt;
                hex1     <= hex1_nxt;
                hex2     <= hex2_nxt;
                hex3     <= hex3_nxt;
                overflow <= ovf_nxt;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_lmc_out_display.sv
// Directed bench for lmc_out_display: table of values with hand-computed
// segment codes, plus sequences for mid-conversion changes, glitches,
// repeated values and reset during a conversion.
module tb_lmc_out_display;

    localparam logic [6:0] B  = 7'b1111111;
    localparam logic [6:0] D  = 7'b0111111;
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] value_in;
    logic [6:0]  hex0, hex1, hex2, hex3;
    logic        busy, overflow, update_pulse;

    int total = 0;
    int bad   = 0;

    lmc_out_display dut (
        .clk          (clk),
        .reset        (reset),
        .value_in     (value_in),
        .hex0         (hex0),
        .hex1         (hex1),
        .hex2         (hex2),
        .hex3         (hex3),
        .busy         (busy),
        .overflow     (overflow),
        .update_pulse (update_pulse)
    );

    // Clock.
    always #10 clk = ~clk;

    typedef struct {
        logic [10:0] v;
        logic [6:0]  h3, h2, h1, h0;
        logic        ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Compare the display against expected codes; leading-zero blanking
    // is applied to the expectation when that build option is on.
    task automatic check_disp(input string name, input logic [6:0] e3, input logic [6:0] e2,
                              input logic [6:0] e1, input logic [6:0] e0, input logic eo);
`ifdef LMC_DISP_LZB_EN
        if (!eo && e2 == S0) begin
            e2 = B;
            if (e1 == S0) e1 = B;
        end
`endif
        check({name, " hex3"}, 32'(hex3), 32'(e3));
        check({name, " hex2"}, 32'(hex2), 32'(e2));
        check({name, " hex1"}, 32'(hex1), 32'(e1));
        check({name, " hex0"}, 32'(hex0), 32'(e0));
        check({name, " ovf"},  32'(overflow), 32'(eo));
    endtask

    // Wait for update_pulse; report busy-high cycles and pulse distance
    // from the busy rising sample.
    task automatic wait_conv(output bit got, output int busy_len, output int lat);
        int rose;
        got = 0; busy_len = 0; lat = -1; rose = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (busy) begin
                if (rose < 0) rose = i;
                busy_len++;
            end
            if (update_pulse) begin
                got = 1;
                lat = i - rose;
                break;
            end
        end
    endtask

    task automatic count_pulses(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (update_pulse) n++;
        end
    endtask

    task automatic wait_busy(output bit got);
        got = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy) begin
                got = 1;
                break;
            end
        end
    endtask

    initial begin
        bit got;
        int blen, lat, np;

        vecs[0] = '{11'd0,    B, S0, S0, S0, 1'b0};
        vecs[1] = '{11'd123,  B, S1, S2, S3, 1'b0};
        vecs[2] = '{11'h7D3,  D, S0, S4, S5, 1'b0};
        vecs[3] = '{11'd1000, D, D,  D,  D,  1'b1};
        vecs[4] = '{11'h400,  D, D,  D,  D,  1'b1};
        vecs[5] = '{11'd999,  B, S9, S9, S9, 1'b0};
        vecs[6] = '{11'h419,  D, S9, S9, S9, 1'b0};
        vecs[7] = '{11'h7FF,  D, S0, S0, S1, 1'b0};

        // Reset state.
        reset = 1'b1;
        value_in = 11'd0;
        repeat (3) @(negedge clk);
        check_disp("reset", B, B, B, B, 1'b0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset pulse", 32'(update_pulse), 32'd0);
        reset = 1'b0;

        // Table: each value converts once with 12 busy cycles.
        for (int k = 0; k < 8; k++) begin
            value_in = vecs[k].v;
            wait_conv(got, blen, lat);
            check($sformatf("vec%0d pulse", k), 32'(got), 32'd1);
            if (got) begin
                check_disp($sformatf("vec%0d", k), vecs[k].h3, vecs[k].h2, vecs[k].h1,
                           vecs[k].h0, vecs[k].ovf);
                check($sformatf("vec%0d busy_len", k), 32'(blen), 32'd12);
                check($sformatf("vec%0d latency", k), 32'(lat), 32'd12);
                @(negedge clk);
                check($sformatf("vec%0d pulse width", k), 32'(update_pulse), 32'd0);
            end
        end

        // Same value held: no reconversion.
        value_in = 11'h7FF;
        count_pulses(40, np);
        check("same value pulses", 32'(np), 32'd0);

        // Two-cycle glitch to 9 is filtered out.
        value_in = 11'd9;
        repeat (2) @(negedge clk);
        value_in = 11'h7FF;
        count_pulses(40, np);
        check("glitch pulses", 32'(np), 32'd0);
        check_disp("after glitch", D, S0, S0, S1, 1'b0);

        // 5 then 7 changed on the third SHIFT cycle: both display in order.
        value_in = 11'd5;
        wait_busy(got);
        check("5 busy start", 32'(got), 32'd1);
        repeat (2) @(negedge clk);
        value_in = 11'd7;
        wait_conv(got, blen, lat);
        check("5 pulse", 32'(got), 32'd1);
        check_disp("show 5", B, S0, S0, S5, 1'b0);
        wait_conv(got, blen, lat);
        check("7 pulse", 32'(got), 32'd1);
        check_disp("show 7", B, S0, S0, S7, 1'b0);
        check("7 busy_len", 32'(blen), 32'd12);

        // Reset during SHIFT clears outputs at once; held value reconverts.
        value_in = 11'd123;
        wait_busy(got);
        check("123 busy start", 32'(got), 32'd1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        check_disp("mid reset", B, B, B, B, 1'b0);
        check("mid reset busy", 32'(busy), 32'd0);
        check("mid reset pulse", 32'(update_pulse), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_conv(got, blen, lat);
        check("after reset pulse", 32'(got), 32'd1);
        check_disp("after reset", B, S1, S2, S3, 1'b0);
        check("after reset busy_len", 32'(blen), 32'd12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
